ctrl_param_bank: RTL
====================

CTRL_PARAM_BANK -- requirements
Module: ctrl_param_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of channels; power of 2, 2..8.
REQ-002 SHALL have parameter N_SLOT, default 4, number of time slots; power of 2, 2..8.
REQ-003 SHALL define CW=log2(N_CH), SW=log2(N_SLOT), AW=4+CW+SW.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 i_wr_valid  in  1  host write request.
REQ-007 o_wr_ready  out  1  write accepted when high together with i_wr_valid.
REQ-008 i_wr_addr  in  AW  {field[3:0], ch[CW-1:0], slot[SW-1:0]}.
REQ-009 i_wr_data  in  16  write data, LSB-aligned to the field width.
REQ-010 o_wr_err  out  1  one-cycle pulse on an accepted write with an unmapped field.
REQ-011 i_commit  in  1  request shadow->active copy at the next frame boundary.
REQ-012 i_frame_sync  in  1  one-cycle frame boundary pulse.
REQ-013 o_commit_done  out  1  one-cycle pulse in the cycle after the copy.
REQ-014 i_slot  in  SW  current slot selector.
REQ-015 o_ts_time  out  16*N_SLOT  active slot periods, slot k at bits [16k+15:16k].
REQ-016 o_pulse_mask/o_pulse_hit/o_pulse_gnd/o_pulse_count/o_pulse_hush/o_adc_vchn/o_adc_tick/o_adc_ratio  out  N_CH*{N_CH,8,8,4,16,CW,8,8}  channel c's value for i_slot, packed with c=0 in the LSBs.

Function
REQ-017 Field codes SHALL be: 0 ts_time (ch ignored), 1 mask, 2 hit, 3 gnd, 4 count, 5 hush, 6 vchn, 7 tick, 8 ratio; codes 9-15 are unmapped.
REQ-018 SHALL hold two copies of every parameter, shadow and active; host writes SHALL update shadow only.
REQ-019 An accepted write SHALL update the addressed shadow entry at that clock edge; an unmapped field SHALL change nothing and SHALL pulse o_wr_err on the next cycle.
REQ-020 SHALL use an FSM with states IDLE and PEND: i_commit in IDLE -> PEND; in PEND, i_frame_sync -> copy all shadow to active in one edge -> IDLE.
REQ-021 o_wr_ready SHALL equal (state==IDLE), so writes stall while a commit is pending.
REQ-022 When i_commit and i_frame_sync are high together in IDLE, the FSM SHALL enter PEND and wait for the next i_frame_sync; the copy SHALL NOT happen in the same cycle.
REQ-023 When i_wr_valid and i_commit are high together in IDLE, the write SHALL be accepted and included in the commit.
REQ-024 i_commit in PEND SHALL be ignored.
REQ-025 Per-channel outputs SHALL be registered: active[c][i_slot] appears one cycle after i_slot is sampled, and a commit is visible one cycle after the copy edge.
REQ-026 o_ts_time SHALL be driven directly from the active registers.
REQ-027 Writes SHALL truncate i_wr_data to the field width; there is no saturation.

Reset
REQ-028 Reset SHALL force both shadow and active to defaults and the FSM to IDLE; o_wr_err=0, o_commit_done=0.
REQ-029 Defaults: ts_time=9000 for slots 0..N_SLOT-2 and 5000 for the last slot; mask=1<<(c mod N_CH); hit=100, gnd=100, count=4 (last ch/last slot: 20/180/1); hush=1000; vchn=c; tick=128; ratio=8.
REQ-030 Registered outputs SHALL reset to the slot-0 defaults.
REQ-031 rst_n asserted mid-PEND SHALL abort the commit without any copy.

Configuration
REQ-032 With CTRL_PARAM_READBACK_EN defined, the block SHALL add ports i_rd_valid (1), i_rd_addr (AW), o_rd_valid (1) and o_rd_data (16), returning the shadow value zero-extended 1 cycle later, with 0 for unmapped fields.
REQ-033 Without CTRL_PARAM_READBACK_EN, these ports and the readback logic SHALL be absent.

Verification
REQ-034 Release reset, i_slot=0 -> o_pulse_hit ch3 = 100, o_ts_time slot3 = 5000, o_wr_ready=1.
REQ-035 Write field2/ch1/slot2 = 0x55, no commit, then i_slot=2 -> output still 100; commit then frame_sync -> 0x55 one cycle after the copy, with o_commit_done pulsing.
REQ-036 i_commit and i_frame_sync together -> no copy, o_wr_ready=0; the next frame_sync copies.
REQ-037 Write with field 12 -> o_wr_err pulses once and all shadow contents are unchanged.
REQ-038 Assert rst_n during PEND after a write of 0x1234 to hush -> hush returns to 1000 and o_wr_ready=1.
REQ-039 With CTRL_PARAM_READBACK_EN: write tick=0xAB, then read the same address -> o_rd_data=0x00AB with o_rd_valid one cycle after i_rd_valid.

Source files
------------

// File: rtl/ctrl_param_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_param_bank
//  Brief    : Double-buffered (shadow/active) per-channel, per-slot control
//             parameter bank. Host writes land in shadow; a commit copies
//             shadow to active on the next frame boundary.
//  Options  : CTRL_PARAM_READBACK_EN adds a shadow readback port.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_param_bank #(
  parameter int N_CH   = 4,
  parameter int N_SLOT = 4,
  localparam int CW    = $clog2(N_CH),
  localparam int SW    = $clog2(N_SLOT),
  localparam int AW    = 4 + CW + SW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [15:0]          i_wr_data,
  output logic                 o_wr_err,
  input  logic                 i_commit,
  input  logic                 i_frame_sync,
  output logic                 o_commit_done,
  input  logic [SW-1:0]        i_slot,
  output logic [16*N_SLOT-1:0] o_ts_time,
  output logic [N_CH*N_CH-1:0] o_pulse_mask,
  output logic [N_CH*8-1:0]    o_pulse_hit,
  output logic [N_CH*8-1:0]    o_pulse_gnd,
  output logic [N_CH*4-1:0]    o_pulse_count,
  output logic [N_CH*16-1:0]   o_pulse_hush,
  output logic [N_CH*CW-1:0]   o_adc_vchn,
  output logic [N_CH*8-1:0]    o_adc_tick,
  output logic [N_CH*8-1:0]    o_adc_ratio
`ifdef CTRL_PARAM_READBACK_EN
  ,
  input  logic                 i_rd_valid,
  input  logic [AW-1:0]        i_rd_addr,
  output logic                 o_rd_valid,
  output logic [15:0]          o_rd_data
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Shadow copies (host-written)
  logic [15:0]     r_sh_ts    [N_SLOT];
  logic [N_CH-1:0] r_sh_mask  [N_CH][N_SLOT];
  logic [7:0]      r_sh_hit   [N_CH][N_SLOT];
  logic [7:0]      r_sh_gnd   [N_CH][N_SLOT];
  logic [3:0]      r_sh_count [N_CH][N_SLOT];
  logic [15:0]     r_sh_hush  [N_CH][N_SLOT];
  logic [CW-1:0]   r_sh_vchn  [N_CH][N_SLOT];
  logic [7:0]      r_sh_tick  [N_CH][N_SLOT];
  logic [7:0]      r_sh_ratio [N_CH][N_SLOT];
  // Active copies (what the datapath sees)
  logic [15:0]     r_ac_ts    [N_SLOT];
  logic [N_CH-1:0] r_ac_mask  [N_CH][N_SLOT];
  logic [7:0]      r_ac_hit   [N_CH][N_SLOT];
  logic [7:0]      r_ac_gnd   [N_CH][N_SLOT];
  logic [3:0]      r_ac_count [N_CH][N_SLOT];
  logic [15:0]     r_ac_hush  [N_CH][N_SLOT];
  logic [CW-1:0]   r_ac_vchn  [N_CH][N_SLOT];
  logic [7:0]      r_ac_tick  [N_CH][N_SLOT];
  logic [7:0]      r_ac_ratio [N_CH][N_SLOT];

  logic [0:0]    r_state;
  logic          r_wr_err;
  logic          r_commit_done;
  logic          w_wr_acc;
  logic          w_copy;
  logic [3:0]    w_fld;
  logic [CW-1:0] w_ch;
  logic [SW-1:0] w_slot;

  assign w_fld    = i_wr_addr[AW-1 -: 4];
  assign w_ch     = i_wr_addr[SW +: CW];
  assign w_slot   = i_wr_addr[SW-1:0];
  assign w_wr_acc = i_wr_valid && (r_state == ST_IDLE);
  assign w_copy   = (r_state == ST_PEND) && i_frame_sync;

  assign o_wr_ready    = (r_state == ST_IDLE);
  assign o_wr_err      = r_wr_err;
  assign o_commit_done = r_commit_done;

  // Shadow bank: reset to defaults, host writes truncated to field width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SLOT; s++) begin
        r_sh_ts[s] <= (s == N_SLOT-1) ? 16'd5000 : 16'd9000;
        for (int c = 0; c < N_CH; c++) begin
          r_sh_mask[c][s]  <= N_CH'(1 << c);
          r_sh_hit[c][s]   <= (c == N_CH-1 && s == N_SLOT-1) ? 8'd20  : 8'd100;
          r_sh_gnd[c][s]   <= (c == N_CH-1 && s == N_SLOT-1) ? 8'd180 : 8'd100;
          r_sh_count[c][s] <= (c == N_CH-1 && s == N_SLOT-1) ? 4'd1   : 4'd4;
          r_sh_hush[c][s]  <= 16'd1000;
          r_sh_vchn[c][s]  <= CW'(c);
          r_sh_tick[c][s]  <= 8'd128;
          r_sh_ratio[c][s] <= 8'd8;
        end
      end
    end else if (w_wr_acc) begin
      case (w_fld)
        4'd0: r_sh_ts[w_slot]            <= i_wr_data;
        4'd1: r_sh_mask[w_ch][w_slot]    <= i_wr_data[N_CH-1:0];
        4'd2: r_sh_hit[w_ch][w_slot]     <= i_wr_data[7:0];
        4'd3: r_sh_gnd[w_ch][w_slot]     <= i_wr_data[7:0];
        4'd4: r_sh_count[w_ch][w_slot]   <= i_wr_data[3:0];
        4'd5: r_sh_hush[w_ch][w_slot]    <= i_wr_data;
        4'd6: r_sh_vchn[w_ch][w_slot]    <= i_wr_data[CW-1:0];
        4'd7: r_sh_tick[w_ch][w_slot]    <= i_wr_data[7:0];
        4'd8: r_sh_ratio[w_ch][w_slot]   <= i_wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Active bank: reset to defaults, whole-bank copy from shadow on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SLOT; s++) begin
        r_ac_ts[s] <= (s == N_SLOT-1) ? 16'd5000 : 16'd9000;
        for (int c = 0; c < N_CH; c++) begin
          r_ac_mask[c][s]  <= N_CH'(1 << c);
          r_ac_hit[c][s]   <= (c == N_CH-1 && s == N_SLOT-1) ? 8'd20  : 8'd100;
          r_ac_gnd[c][s]   <= (c == N_CH-1 && s == N_SLOT-1) ? 8'd180 : 8'd100;
          r_ac_count[c][s] <= (c == N_CH-1 && s == N_SLOT-1) ? 4'd1   : 4'd4;
          r_ac_hush[c][s]  <= 16'd1000;
          r_ac_vchn[c][s]  <= CW'(c);
          r_ac_tick[c][s]  <= 8'd128;
          r_ac_ratio[c][s] <= 8'd8;
        end
      end
    end else if (w_copy) begin
      for (int s = 0; s < N_SLOT; s++) begin
        r_ac_ts[s] <= r_sh_ts[s];
        for (int c = 0; c < N_CH; c++) begin
          r_ac_mask[c][s]  <= r_sh_mask[c][s];
          r_ac_hit[c][s]   <= r_sh_hit[c][s];
          r_ac_gnd[c][s]   <= r_sh_gnd[c][s];
          r_ac_count[c][s] <= r_sh_count[c][s];
          r_ac_hush[c][s]  <= r_sh_hush[c][s];
          r_ac_vchn[c][s]  <= r_sh_vchn[c][s];
          r_ac_tick[c][s]  <= r_sh_tick[c][s];
          r_ac_ratio[c][s] <= r_sh_ratio[c][s];
        end
      end
    end
  end

  // Commit FSM: a commit arms PEND; the next frame sync performs the copy.
  // A frame sync coincident with the commit request does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_commit)     r_state <= ST_PEND;
        ST_PEND: if (i_frame_sync) r_state <= ST_IDLE;
        default:                   r_state <= ST_IDLE;
      endcase
    end
  end

  // Status pulses, one cycle after the triggering edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err      <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_wr_err      <= w_wr_acc && (w_fld > 4'd8);
      r_commit_done <= w_copy;
    end
  end

  generate
    for (genvar s = 0; s < N_SLOT; s++) begin : g_ts
      assign o_ts_time[16*s +: 16] = r_ac_ts[s];
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [N_CH-1:0] r_mask;
      logic [7:0]      r_hit;
      logic [7:0]      r_gnd;
      logic [3:0]      r_count;
      logic [15:0]     r_hush;
      logic [CW-1:0]   r_vchn;
      logic [7:0]      r_tick;
      logic [7:0]      r_ratio;

      // Registered per-channel view of the active bank for the selected slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mask  <= N_CH'(1 << c);
          r_hit   <= 8'd100;
          r_gnd   <= 8'd100;
          r_count <= 4'd4;
          r_hush  <= 16'd1000;
          r_vchn  <= CW'(c);
          r_tick  <= 8'd128;
          r_ratio <= 8'd8;
        end else begin
          r_mask  <= r_ac_mask[c][i_slot];
          r_hit   <= r_ac_hit[c][i_slot];
          r_gnd   <= r_ac_gnd[c][i_slot];
          r_count <= r_ac_count[c][i_slot];
          r_hush  <= r_ac_hush[c][i_slot];
          r_vchn  <= r_ac_vchn[c][i_slot];
          r_tick  <= r_ac_tick[c][i_slot];
          r_ratio <= r_ac_ratio[c][i_slot];
        end
      end

      assign o_pulse_mask[N_CH*c +: N_CH] = r_mask;
      assign o_pulse_hit[8*c +: 8]        = r_hit;
      assign o_pulse_gnd[8*c +: 8]        = r_gnd;
      assign o_pulse_count[4*c +: 4]      = r_count;
      assign o_pulse_hush[16*c +: 16]     = r_hush;
      assign o_adc_vchn[CW*c +: CW]       = r_vchn;
      assign o_adc_tick[8*c +: 8]         = r_tick;
      assign o_adc_ratio[8*c +: 8]        = r_ratio;
    end
  endgenerate

`ifdef CTRL_PARAM_READBACK_EN
  logic [3:0]    w_rd_fld;
  logic [CW-1:0] w_rd_ch;
  logic [SW-1:0] w_rd_slot;
  logic [15:0]   w_rd_val;
  logic          r_rd_valid;
  logic [15:0]   r_rd_data;

  assign w_rd_fld  = i_rd_addr[AW-1 -: 4];
  assign w_rd_ch   = i_rd_addr[SW +: CW];
  assign w_rd_slot = i_rd_addr[SW-1:0];

  // Select the addressed shadow entry, zero-extended; unmapped reads give 0
  always_comb begin
    w_rd_val = 16'd0;
    case (w_rd_fld)
      4'd0: w_rd_val = r_sh_ts[w_rd_slot];
      4'd1: w_rd_val = 16'(r_sh_mask[w_rd_ch][w_rd_slot]);
      4'd2: w_rd_val = 16'(r_sh_hit[w_rd_ch][w_rd_slot]);
      4'd3: w_rd_val = 16'(r_sh_gnd[w_rd_ch][w_rd_slot]);
      4'd4: w_rd_val = 16'(r_sh_count[w_rd_ch][w_rd_slot]);
      4'd5: w_rd_val = r_sh_hush[w_rd_ch][w_rd_slot];
      4'd6: w_rd_val = 16'(r_sh_vchn[w_rd_ch][w_rd_slot]);
      4'd7: w_rd_val = 16'(r_sh_tick[w_rd_ch][w_rd_slot]);
      4'd8: w_rd_val = 16'(r_sh_ratio[w_rd_ch][w_rd_slot]);
      default: w_rd_val = 16'd0;
    endcase
  end

  // Readback response one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'd0;
    end else begin
      r_rd_valid <= i_rd_valid;
      r_rd_data  <= i_rd_valid ? w_rd_val : 16'd0;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
`endif

endmodule
`default_nettype wire
